// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-port memory reads and
// buffers {pc,instr} pairs in a small FIFO handed to decode over valid/ready.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_read,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_instr,
  input  logic        mem_valid,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  input  logic        id_ready,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_e;

  state_e         state_q, state_d;
  logic [63:0]    pc_q, pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]    fetch_count_q, fetch_count_d;
  logic [63:0]    fifo_pc_q [QDEPTH];
  logic [63:0]    fifo_pc_d [QDEPTH];
  logic [31:0]    fifo_instr_q [QDEPTH];
  logic [31:0]    fifo_instr_d [QDEPTH];

  logic redir;
  logic push;
  logic pop;

  // Handshake and issue decisions; count is the registered occupancy.
  always_comb begin
    redir    = redirect_valid && (state_q != S_IDLE);
    mem_read = (state_q == S_FETCH) && !halt && !redirect_valid && (count_q < CW'(QDEPTH));
    push     = mem_read && mem_valid;
    id_valid = (count_q != '0) && !redirect_valid;
    pop      = id_valid && id_ready;
  end

  assign mem_addr    = pc_q;
  assign id_pc       = fifo_pc_q[rd_ptr_q];
  assign id_instr    = fifo_instr_q[rd_ptr_q];
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = fetch_count_q;

  // Next-state: redirect flushes the FIFO and overrides push/pop.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fetch_count_d = fetch_count_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;

    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (halt && !redirect_valid) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    if (redir) begin
      state_d  = S_FETCH;
      pc_d     = redirect_pc & ~64'd3;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = pc_q;
        fifo_instr_d[wr_ptr_q] = mem_instr;
        wr_ptr_d               = wr_ptr_q + PW'(1);
        pc_d                   = pc_q + 64'd4;
        fetch_count_d          = fetch_count_q + 32'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fetch_count_q <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        fifo_pc_q[i]    <= 64'h0;
        fifo_instr_q[i] <= NOP;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fetch_count_q <= fetch_count_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: scenarios queue the {pc,instr} pairs they expect
// decode to receive; a monitor pops and compares on every accepted handshake.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic [63:0] mem_addr;
  logic [31:0] mem_instr;
  logic        mem_valid;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_ready;
  logic        halted;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_ctrl #(.RESET_PC(64'h0), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_instr(mem_instr), .mem_valid(mem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .halted(halted), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Instruction memory model: word returned for whatever address is presented.
  assign mem_instr = instr_of(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (reset && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pop: got id_pc=%h, required no pop", id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (id_pc !== mon_e.pc) begin
          n_fail++; $display("FAIL pop_pc: got %h, required %h", id_pc, mon_e.pc);
        end
        n_checks++;
        if (id_instr !== mon_e.instr) begin
          n_fail++; $display("FAIL pop_instr: got %h, required %h", id_instr, mon_e.instr);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic expect_push(input logic [63:0] pc);
    exp_q.push_back('{pc: pc, instr: instr_of(pc)});
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_valid = 1'b0; id_ready = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %b, required 0", mem_read); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b, required 0", id_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b, required 0", halted); end
    n_checks++; if (id_instr !== 32'h13) begin n_fail++; $display("FAIL rst_id_instr: got %h, required 00000013", id_instr); end
    n_checks++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL rst_id_pc: got %h, required 0", id_pc); end
    n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_count: got %0d, required 0", fetch_count); end
    n_checks++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL idle_mem_read: got %b, required 0", mem_read); end
    next_cycle(); @(negedge clk);
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL first_mem_read: got %b, required 1", mem_read); end
    n_checks++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL first_mem_addr: got %h, required 0", mem_addr); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL first_id_valid: got %b, required 0", id_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      mem_valid = 1'b1; id_ready = 1'b1;
      expect_push(64'(4 * i));
      @(negedge clk);
      n_checks++;
      if (mem_read !== 1'b1 || mem_addr !== 64'(4 * i)) begin
        n_fail++; $display("FAIL stream_issue: got read=%b addr=%h, required read=1 addr=%h", mem_read, mem_addr, 64'(4 * i));
      end
      if (i > 0) begin
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: got %b, required 1 at step %0d", id_valid, i); end
      end
    end
    next_cycle(); mem_valid = 1'b0; @(negedge clk);
    n_checks++; if (fetch_count !== 32'd6) begin n_fail++; $display("FAIL stream_count: got %0d, required 6", fetch_count); end
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_last_valid: got %b, required 1", id_valid); end
    next_cycle(); @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b, required 0", id_valid); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h0; mem_valid = 1'b1; id_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL bp_redir_read: got %b, required 0", mem_read); end
    next_cycle(); redirect_valid = 1'b0; expect_push(64'h0);
    next_cycle(); expect_push(64'h4);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); @(negedge clk);
      n_checks++;
      if (mem_read !== 1'b0 || mem_addr !== 64'h8) begin
        n_fail++; $display("FAIL bp_full: got read=%b addr=%h, required read=0 addr=8", mem_read, mem_addr);
      end
    end
    next_cycle(); id_ready = 1'b1; @(negedge clk);
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL bp_same_cycle_slot: got %b, required 0", mem_read); end
    next_cycle(); expect_push(64'h8); @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 64'h8) begin
      n_fail++; $display("FAIL bp_resume: got read=%b addr=%h, required read=1 addr=8", mem_read, mem_addr);
    end
    next_cycle(); expect_push(64'hC);
    next_cycle(); mem_valid = 1'b0;
    next_cycle(); @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b, required 0", id_valid); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h8; mem_valid = 1'b1; id_ready = 1'b0;
    next_cycle(); redirect_valid = 1'b0; expect_push(64'h8);
    next_cycle(); expect_push(64'hC);
    next_cycle(); @(negedge clk);
    n_checks++; if (id_pc !== 64'h8 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL redir_setup: got id_pc=%h read=%b, required id_pc=8 read=0", id_pc, mem_read);
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h27; id_ready = 1'b1; exp_q.delete();
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_id_valid: got %b, required 0", id_valid); end
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL redir_mem_read: got %b, required 0", mem_read); end
    next_cycle(); redirect_valid = 1'b0; expect_push(64'h24); @(negedge clk);
    n_checks++; if (mem_addr !== 64'h24 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL redir_target: got addr=%h read=%b, required addr=24 read=1", mem_addr, mem_read);
    end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flushed: got %b, required 0", id_valid); end
    next_cycle(); mem_valid = 1'b0; @(negedge clk);
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_first_valid: got %b, required 1", id_valid); end
    next_cycle(); @(negedge clk);
    n_checks++; if (fetch_count !== 32'd13) begin n_fail++; $display("FAIL redir_count: got %0d, required 13", fetch_count); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_mem_stall();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h10; mem_valid = 1'b0; id_ready = 1'b1;
    next_cycle(); redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_addr !== 64'h10 || mem_read !== 1'b1 || fetch_count !== 32'd13) begin
        n_fail++; $display("FAIL stall_hold: got addr=%h read=%b cnt=%0d, required addr=10 read=1 cnt=13", mem_addr, mem_read, fetch_count);
      end
      next_cycle();
    end
    mem_valid = 1'b1; expect_push(64'h10);
    next_cycle(); mem_valid = 1'b0; @(negedge clk);
    n_checks++; if (fetch_count !== 32'd14 || mem_addr !== 64'h14) begin
      n_fail++; $display("FAIL stall_resume: got cnt=%0d addr=%h, required cnt=14 addr=14", fetch_count, mem_addr);
    end
    next_cycle(); @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_halt_reset();
    next_cycle(); mem_valid = 1'b1; id_ready = 1'b0; expect_push(64'h14);
    next_cycle(); expect_push(64'h18);
    next_cycle(); halt = 1'b1; @(negedge clk);
    n_checks++; if (mem_read !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_req: got read=%b halted=%b, required read=0 halted=0", mem_read, halted);
    end
    next_cycle(); id_ready = 1'b1; @(negedge clk);
    n_checks++; if (halted !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL halt_state: got halted=%b read=%b, required halted=1 read=0", halted, mem_read);
    end
    next_cycle(); halt = 1'b0; @(negedge clk);
    n_checks++; if (halted !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++; $display("FAIL halt_sticky: got halted=%b read=%b, required halted=1 read=0", halted, mem_read);
    end
    next_cycle(); @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drained: got %b, required 0", id_valid); end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h40; @(negedge clk);
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL halt_redir_read: got %b, required 0", mem_read); end
    next_cycle(); redirect_valid = 1'b0; id_ready = 1'b0; expect_push(64'h40); @(negedge clk);
    n_checks++; if (halted !== 1'b0 || mem_addr !== 64'h40 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL halt_resume: got halted=%b addr=%h read=%b, required 0/40/1", halted, mem_addr, mem_read);
    end
    next_cycle(); expect_push(64'h44);
    @(posedge clk); #2;
    n_checks++; if (fetch_count !== 32'd18 || id_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got cnt=%0d valid=%b, required cnt=18 valid=1", fetch_count, id_valid);
    end
    #1; reset = 1'b0; exp_q.delete(); #1;
    n_checks++; if (mem_read !== 1'b0 || id_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL async_ctrl: got read=%b valid=%b halted=%b, required 0/0/0", mem_read, id_valid, halted);
    end
    n_checks++; if (id_pc !== 64'h0 || id_instr !== 32'h13 || mem_addr !== 64'h0 || fetch_count !== 32'h0) begin
      n_fail++; $display("FAIL async_data: got pc=%h instr=%h addr=%h cnt=%0d, required 0/00000013/0/0", id_pc, id_instr, mem_addr, fetch_count);
    end
    next_cycle(); mem_valid = 1'b0; reset = 1'b1; @(negedge clk);
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b, required 0", mem_read); end
    next_cycle(); @(negedge clk);
    n_checks++; if (mem_read !== 1'b1 || mem_addr !== 64'h0) begin
      n_fail++; $display("FAIL post_reset_fetch: got read=%b addr=%h, required read=1 addr=0", mem_read, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_mem_stall();
    test_halt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
